arm_cmd_arbiter: RTL and testbench

//  Merges the two joystick-style command sources (PS/2 keyboard, HC-06 Bluetooth UART) into
//  per-joint jog commands feeding the four servo_controller instances. Owns the shared servo

---
 rtl/arm_cmd_pkg.sv | 33 +++
 rtl/bt_cmd_decoder.sv | 97 +++++++++
 rtl/arm_cmd_arbiter.sv | 142 ++++++++++++++
 tb/tb_arm_cmd_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_cmd_pkg.sv
// Shared types and constants for the arm command arbiter.
// Holds the joint count, owner/state encodings, the Bluetooth opcode values
// and the packed per-joint jog command payload.
package arm_cmd_pkg;

   localparam int unsigned NUM_JOINTS = 4;
   localparam int unsigned JOINT_W    = $clog2(NUM_JOINTS);

   // Encoding driven on the owner port
   localparam logic [1:0] OWN_IDLE = 2'b00;
   localparam logic [1:0] OWN_KB   = 2'b01;
   localparam logic [1:0] OWN_BT   = 2'b10;

   // Ownership FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_KB   = 2'b01,
      ST_BT   = 2'b10
   } arb_state_e;

   // Bluetooth opcodes; 1..OP_JOG_MAX are jog commands
   localparam logic [7:0] OP_STOP    = 8'h00;
   localparam logic [7:0] OP_JOG_MAX = 8'h08;
   localparam logic [7:0] OP_ESTOP   = 8'hFF;
   localparam logic [7:0] OP_CLR     = 8'hFE;

   // Per-joint jog request: up = clockwise, down = counter-clockwise
   typedef struct packed {
      logic [NUM_JOINTS-1:0] up;
      logic [NUM_JOINTS-1:0] down;
   } jog_cmd_t;

endpackage

// File: rtl/bt_cmd_decoder.sv
// Bluetooth byte decoder with a timed command hold.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   rx_data     - received UART byte, valid when rx_done=1
//   rx_done     - one-cycle byte strobe
//   bt_cmd      - current BT jog command (at most one joint, one direction)
//   estop       - latched emergency stop (only with ARM_CMD_ESTOP_EN)
// Optional feature macro: ARM_CMD_ESTOP_EN (0xFF latches e-stop, 0xFE clears it).
module bt_cmd_decoder
   import arm_cmd_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 20_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output jog_cmd_t   bt_cmd,
   output logic       estop
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

   jog_cmd_t          cmd_q,  cmd_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [JOINT_W-1:0] joint_c;

   // Bytes 1..8 map to joint (b-1)>>1
   assign joint_c = JOINT_W'((rx_data[2:0] - 3'd1) >> 1);

   // Hold countdown, then byte decode; a new jog byte overrides expiry
   always_comb begin
      cmd_d  = cmd_q;
      hold_d = hold_q;
      if (hold_q != '0) begin
         hold_d = hold_q - HOLD_W'(1);
         if (hold_q == HOLD_W'(1)) begin
            cmd_d = '0;
         end
      end
      if (rx_done) begin
         if ((rx_data >= 8'd1) && (rx_data <= OP_JOG_MAX)) begin
            cmd_d = '0;
            if (rx_data[0]) begin
               cmd_d.up = NUM_JOINTS'(1) << joint_c;
            end else begin
               cmd_d.down = NUM_JOINTS'(1) << joint_c;
            end
            hold_d = HOLD_W'(HOLD_CYCLES);
         end else if (rx_data == OP_STOP) begin
            cmd_d  = '0;
            hold_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q  <= '0;
         hold_q <= '0;
      end else begin
         cmd_q  <= cmd_d;
         hold_q <= hold_d;
      end
   end

   assign bt_cmd = cmd_q;

`ifdef ARM_CMD_ESTOP_EN
   logic estop_q, estop_d;

   // E-stop latch: set by 0xFF, cleared by 0xFE
   always_comb begin
      estop_d = estop_q;
      if (rx_done) begin
         if (rx_data == OP_ESTOP) begin
            estop_d = 1'b1;
         end else if (rx_data == OP_CLR) begin
            estop_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estop_q <= 1'b0;
      end else begin
         estop_q <= estop_d;
      end
   end

   assign estop = estop_q;
`else
   assign estop = 1'b0;
`endif

endmodule

// File: rtl/arm_cmd_arbiter.sv
// Arbitrates the keyboard and Bluetooth jog sources onto the shared servo bank.
// One source owns the bank at a time; ownership is released after the owner
// has been idle for RELEASE_CYCLES.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   kb_up, kb_down   - keyboard levels per joint (cw / ccw)
//   rx_data, rx_done - UART byte and strobe
//   cw, ccw          - registered per-joint servo direction commands
//   owner            - 00 IDLE, 01 KB, 10 BT
// Optional feature macro: ARM_CMD_ESTOP_EN (byte 0xFF e-stop, 0xFE release).
module arm_cmd_arbiter
   import arm_cmd_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = 20_000_000,
   parameter int unsigned RELEASE_CYCLES = 5_000_000,
   parameter int unsigned BT_PRIORITY    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_JOINTS-1:0] kb_up,
   input  logic [NUM_JOINTS-1:0] kb_down,
   input  logic [7:0]            rx_data,
   input  logic                  rx_done,
   output logic [NUM_JOINTS-1:0] cw,
   output logic [NUM_JOINTS-1:0] ccw,
   output logic [1:0]            owner
);

   localparam int unsigned REL_W = (RELEASE_CYCLES < 1) ? 1 : $clog2(RELEASE_CYCLES + 1);

   jog_cmd_t bt_cmd;
   logic     estop;

   bt_cmd_decoder #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_bt_dec (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_data (rx_data),
      .rx_done (rx_done),
      .bt_cmd  (bt_cmd),
      .estop   (estop)
   );

   arb_state_e            state_q, state_d;
   logic [REL_W-1:0]      rel_q,   rel_d;
   logic [NUM_JOINTS-1:0] cw_q,    cw_d;
   logic [NUM_JOINTS-1:0] ccw_q,   ccw_d;
   logic [1:0]            owner_q, owner_d;

   logic                  kb_req_c, bt_req_c, own_req_c;
   logic [NUM_JOINTS-1:0] kb_cw_c,  kb_ccw_c;

   // Both directions pressed on a joint cancels that joint but still counts as a request
   assign kb_req_c  = |(kb_up | kb_down);
   assign kb_cw_c   = kb_up & ~kb_down;
   assign kb_ccw_c  = kb_down & ~kb_up;
   assign bt_req_c  = |(bt_cmd.up | bt_cmd.down);
   assign own_req_c = (state_q == ST_BT) ? bt_req_c : kb_req_c;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rel_q   <= '0;
         cw_q    <= '0;
         ccw_q   <= '0;
         owner_q <= OWN_IDLE;
      end else begin
         state_q <= state_d;
         rel_q   <= rel_d;
         cw_q    <= cw_d;
         ccw_q   <= ccw_d;
         owner_q <= owner_d;
      end
   end

   // Ownership next state and release counter; everything holds during e-stop
   always_comb begin
      state_d = state_q;
      rel_d   = rel_q;
      if (!estop) begin
         case (state_q)
            ST_IDLE: begin
               rel_d = '0;
               if (kb_req_c && bt_req_c) begin
                  state_d = (BT_PRIORITY != 0) ? ST_BT : ST_KB;
               end else if (kb_req_c) begin
                  state_d = ST_KB;
               end else if (bt_req_c) begin
                  state_d = ST_BT;
               end
            end
            ST_KB, ST_BT: begin
               if (own_req_c) begin
                  rel_d = '0;
               end else if ((32'(rel_q) + 32'd1) >= RELEASE_CYCLES) begin
                  state_d = ST_IDLE;
                  rel_d   = '0;
               end else begin
                  rel_d = rel_q + REL_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               rel_d   = '0;
            end
         endcase
      end
   end

   // Outputs follow the owner selected for the next cycle
   always_comb begin
      cw_d    = '0;
      ccw_d   = '0;
      owner_d = OWN_IDLE;
      if (!estop) begin
         case (state_d)
            ST_KB: begin
               cw_d    = kb_cw_c;
               ccw_d   = kb_ccw_c;
               owner_d = OWN_KB;
            end
            ST_BT: begin
               cw_d    = bt_cmd.up;
               ccw_d   = bt_cmd.down;
               owner_d = OWN_BT;
            end
            default: begin
               cw_d    = '0;
               ccw_d   = '0;
               owner_d = OWN_IDLE;
            end
         endcase
      end
   end

   assign cw    = cw_q;
   assign ccw   = ccw_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_arm_cmd_arbiter.sv
// Bench for arm_cmd_arbiter: two instances (keyboard-priority and BT-priority)
// share stimulus and are compared every cycle against a deadline/timestamp model.
module tb_arm_cmd_arbiter;

   localparam int unsigned HOLD = 20;
   localparam int unsigned REL  = 5;

   logic       clk;
   logic       rst_n;
   logic [3:0] kb_up, kb_down;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [3:0] cw0, ccw0, cw1, ccw1;
   logic [1:0] own0, own1;

   arm_cmd_arbiter #(.HOLD_CYCLES(HOLD), .RELEASE_CYCLES(REL), .BT_PRIORITY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .kb_up(kb_up), .kb_down(kb_down),
      .rx_data(rx_data), .rx_done(rx_done), .cw(cw0), .ccw(ccw0), .owner(own0));

   arm_cmd_arbiter #(.HOLD_CYCLES(HOLD), .RELEASE_CYCLES(REL), .BT_PRIORITY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .kb_up(kb_up), .kb_down(kb_down),
      .rx_data(rx_data), .rx_done(rx_done), .cw(cw1), .ccw(ccw1), .owner(own1));

   logic [3:0] d_cw[2], d_ccw[2];
   logic [1:0] d_own[2];
   assign d_cw[0] = cw0;  assign d_ccw[0] = ccw0; assign d_own[0] = own0;
   assign d_cw[1] = cw1;  assign d_ccw[1] = ccw1; assign d_own[1] = own1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic chk_en = 1'b0;

   function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // ---------------- behavioural model ----------------
   // BT command kept as (joint, direction, expiry edge); ownership as owner plus
   // the edge index at which the owner last had an active request.
   longint     cyc;
   logic       m_bt_valid;
   int         m_bt_joint;
   logic       m_bt_cw;
   longint     m_bt_deadline;
   logic       m_estop;
   int         m_own[2];
   longint     m_last[2];
   logic [3:0] m_cw[2], m_ccw[2];
   logic [3:0] mb_up, mb_dn;
   logic       mb_req, mk_req, m_req;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; m_bt_valid = 0; m_bt_joint = 0; m_bt_cw = 0; m_bt_deadline = 0; m_estop = 0;
         for (int i = 0; i < 2; i++) begin
            m_own[i] = 0; m_last[i] = 0; m_cw[i] = 0; m_ccw[i] = 0;
         end
      end else begin
         cyc++;
         mb_up  = (m_bt_valid &&  m_bt_cw) ? 4'(1 << m_bt_joint) : 4'b0;
         mb_dn  = (m_bt_valid && !m_bt_cw) ? 4'(1 << m_bt_joint) : 4'b0;
         mb_req = m_bt_valid;
         mk_req = |(kb_up | kb_down);
         for (int i = 0; i < 2; i++) begin
            if (m_estop) begin
               m_last[i]++;
            end else if (m_own[i] == 0) begin
               if (mk_req && mb_req) m_own[i] = (i == 1) ? 2 : 1;
               else if (mk_req)      m_own[i] = 1;
               else if (mb_req)      m_own[i] = 2;
               m_last[i] = cyc;
            end else begin
               m_req = (m_own[i] == 1) ? mk_req : mb_req;
               if (m_req) m_last[i] = cyc;
               else if (cyc - m_last[i] >= REL) m_own[i] = 0;
            end
            if (m_estop || m_own[i] == 0) begin
               m_cw[i] = 0; m_ccw[i] = 0;
            end else if (m_own[i] == 1) begin
               m_cw[i] = kb_up & ~kb_down; m_ccw[i] = kb_down & ~kb_up;
            end else begin
               m_cw[i] = mb_up; m_ccw[i] = mb_dn;
            end
         end
         if (rx_done && rx_data >= 8'd1 && rx_data <= 8'd8) begin
            m_bt_valid = 1; m_bt_joint = (int'(rx_data) - 1) / 2;
            m_bt_cw = (int'(rx_data) % 2) == 1; m_bt_deadline = cyc + HOLD;
         end else if (rx_done && rx_data == 8'd0) begin
            m_bt_valid = 0;
         end else if (m_bt_valid && cyc >= m_bt_deadline) begin
            m_bt_valid = 0;
         end
`ifdef ARM_CMD_ESTOP_EN
         if (rx_done && rx_data == 8'hFF) m_estop = 1;
         else if (rx_done && rx_data == 8'hFE) m_estop = 0;
`endif
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("cyc%0d_owner%0d", cyc, i), 8'(d_own[i]), 8'(m_own[i]));
            chk($sformatf("cyc%0d_cw%0d", cyc, i), 8'(d_cw[i]), 8'(m_cw[i]));
            chk($sformatf("cyc%0d_ccw%0d", cyc, i), 8'(d_ccw[i]), 8'(m_ccw[i]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   // Hand-computed expectation checked against both the DUT and the model
   task automatic lit(input string name, input int i, input logic [1:0] own,
                      input logic [3:0] ecw, input logic [3:0] eccw);
      chk({name, "_dut_owner"}, 8'(d_own[i]), 8'(own));
      chk({name, "_dut_cw"},    8'(d_cw[i]),  8'(ecw));
      chk({name, "_dut_ccw"},   8'(d_ccw[i]), 8'(eccw));
      chk({name, "_model_owner"}, 8'(m_own[i]), 8'(own));
      chk({name, "_model_cw"},    8'(m_cw[i]),  8'(ecw));
   endtask

   initial begin
      rst_n = 1'b0; kb_up = 0; kb_down = 0; rx_data = 0; rx_done = 0;
      tick(2);
      lit("reset0", 0, 2'b00, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Reset mid-jog
      kb_up = 4'b0001;
      tick(2);
      lit("kb_jog", 0, 2'b01, 4'b0001, 4'b0000);
      #2 rst_n = 1'b0;
      #1 lit("reset_mid", 0, 2'b00, 4'b0000, 4'b0000);
      lit("reset_mid1", 1, 2'b00, 4'b0000, 4'b0000);
      kb_up = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // BT byte 3 from IDLE, hold expiry then release
      send_byte(8'd3);
      tick(1);
      lit("bt_grant", 0, 2'b10, 4'b0010, 4'b0000);
      tick(19);
      lit("bt_hold_last", 0, 2'b10, 4'b0010, 4'b0000);
      tick(1);
      lit("bt_expired", 0, 2'b10, 4'b0000, 4'b0000);
      tick(3);
      lit("bt_not_rel", 0, 2'b10, 4'b0000, 4'b0000);
      tick(1);
      lit("bt_released", 0, 2'b00, 4'b0000, 4'b0000);

      // Simultaneous claim in IDLE: priority decides
      send_byte(8'd2);
      kb_up = 4'b0001;
      tick(1);
      lit("prio0", 0, 2'b01, 4'b0001, 4'b0000);
      lit("prio1", 1, 2'b10, 4'b0000, 4'b0001);
      kb_up = 0;
      send_byte(8'd0);
      tick(10);
      lit("prio_idle0", 0, 2'b00, 4'b0000, 4'b0000);
      lit("prio_idle1", 1, 2'b00, 4'b0000, 4'b0000);

      // Keyboard masked while BT owns; hand-over after BT stops
      send_byte(8'd5);
      tick(1);
      kb_down = 4'b0100;
      tick(8);
      for (int k = 0; k < 3; k++) begin
         send_byte(8'd5);
         tick(9);
      end
      lit("bt_masks_kb", 0, 2'b10, 4'b0100, 4'b0000);
      send_byte(8'd5);
      tick(HOLD + REL + 3);
      lit("handover_kb", 0, 2'b01, 4'b0000, 4'b0100);
      kb_down = 0;
      tick(7);
      lit("handover_idle", 0, 2'b00, 4'b0000, 4'b0000);

      // Up and down together cancel the joint but keep ownership
      kb_up = 4'b0001; kb_down = 4'b0001;
      tick(2);
      lit("kb_conflict", 0, 2'b01, 4'b0000, 4'b0000);
      tick(10);
      lit("kb_conflict_held", 0, 2'b01, 4'b0000, 4'b0000);
      kb_up = 0; kb_down = 0;
      tick(7);

      // New byte on the expiry edge reloads the hold
      send_byte(8'd1);
      tick(19);
      send_byte(8'd3);
      tick(1);
      lit("expiry_reload", 0, 2'b10, 4'b0010, 4'b0000);
      tick(5);
      lit("expiry_reload_held", 0, 2'b10, 4'b0010, 4'b0000);
      send_byte(8'd0);
      tick(8);

`ifdef ARM_CMD_ESTOP_EN
      send_byte(8'd1);
      tick(1);
      lit("es_pre", 0, 2'b10, 4'b0001, 4'b0000);
      send_byte(8'hFF);
      tick(1);
      lit("es_set", 0, 2'b00, 4'b0000, 4'b0000);
      send_byte(8'd1);
      tick(2);
      lit("es_frozen", 0, 2'b00, 4'b0000, 4'b0000);
      send_byte(8'hFE);
      send_byte(8'd1);
      tick(1);
      lit("es_clear", 0, 2'b10, 4'b0001, 4'b0000);
`else
      send_byte(8'd1);
      send_byte(8'hFF);
      tick(1);
      lit("ff_ignored", 0, 2'b10, 4'b0001, 4'b0000);
`endif
      send_byte(8'd0);
      tick(8);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 3))
               0, 1: begin kb_up = 0; kb_down = 0; end
               2:    begin kb_up = 4'($urandom); kb_down = 0; end
               default: begin kb_up = 4'($urandom); kb_down = 4'($urandom); end
            endcase
         end
         if ($urandom_range(0, 14) == 0) begin
            int r;
            r = int'($urandom_range(0, 15));
            rx_done = 1'b1;
            if (r <= 8)       rx_data = 8'(r);
            else if (r == 9)  rx_data = 8'hFF;
            else if (r == 10) rx_data = 8'hFE;
            else              rx_data = 8'($urandom);
         end else begin
            rx_done = 1'b0;
         end
         @(negedge clk);
      end
      rx_done = 1'b0;
      tick(2);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
